data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 46 ++++
 rtl/data_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory bus seen by data_mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface data_mem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;
    logic        p0_stall;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic [31:0] mem_address;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err, p0_stall,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_address, mem_memWrite, mem_memRead, mem_writeData,
        input  mem_readData
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err, p0_stall,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_address, mem_memWrite, mem_memRead, mem_writeData,
        output mem_readData
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: pipeline port p0 has priority,
// loader/debug port p1 is protected from starvation; responses return two cycles after grant.
module data_mem_arbiter #(
    parameter int DEPTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_arbiter_if.slave  bus
);

    localparam int              CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [31:0]     DEPTH_W = 32'(DEPTH);

    typedef struct packed {
        logic valid;
        logic port;
        logic we;
        logic err;
    } tag_t;

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    tag_t          tag1_q;
    tag_t          tag1_d;
    tag_t          tag2_q;
    tag_t          tag2_d;
    logic [31:0]   mem_address_q;
    logic [31:0]   mem_address_d;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   mem_wdata_d;
    logic          mem_write_q;
    logic          mem_write_d;
    logic          mem_read_q;
    logic          mem_read_d;
    logic [31:0]   p0_rdata_q;
    logic [31:0]   p0_rdata_d;
    logic [31:0]   p1_rdata_q;
    logic [31:0]   p1_rdata_d;

    logic          starve_force;
    logic          p0_win;
    logic          p1_win;
    logic          any_gnt;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_oor;
    logic [31:0]   resp_data;

    // Grants are masked while reset is low so no request can slip through during reset.
    always_comb begin
        starve_force = bus.p1_req && (starve_q == LIMIT);
        p1_win       = reset && bus.p1_req && (starve_force || !bus.p0_req);
        p0_win       = reset && bus.p0_req && !starve_force;
        any_gnt      = p0_win || p1_win;

        sel_we    = p1_win ? bus.p1_we    : bus.p0_we;
        sel_addr  = p1_win ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = p1_win ? bus.p1_wdata : bus.p0_wdata;
        sel_oor   = sel_addr >= DEPTH_W;
    end

    always_comb begin
        starve_d = '0;
        if (bus.p1_req && !p1_win) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
        end

        tag1_d       = '0;
        tag1_d.valid = any_gnt;
        tag1_d.port  = p1_win;
        tag1_d.we    = sel_we;
        tag1_d.err   = sel_oor;
        tag2_d       = tag1_q;

        mem_address_d = any_gnt ? sel_addr : mem_address_q;
        mem_wdata_d   = any_gnt ? sel_wdata : mem_wdata_q;
        mem_write_d   = any_gnt && sel_we && !sel_oor;
        mem_read_d    = any_gnt && !sel_we && !sel_oor;

        // Memory output is only meaningful for an in-range read; out-of-range reads return zero.
        resp_data  = tag1_q.err ? 32'h0 : bus.mem_readData;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        if (tag1_q.valid && !tag1_q.we) begin
            if (tag1_q.port) begin
                p1_rdata_d = resp_data;
            end else begin
                p0_rdata_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q      <= '0;
            tag1_q        <= '0;
            tag2_q        <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
        end else begin
            starve_q      <= starve_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_rdata_q    <= p1_rdata_d;
        end
    end

    assign bus.p0_gnt   = p0_win;
    assign bus.p1_gnt   = p1_win;
    assign bus.p0_stall = bus.p0_req && !p0_win;

    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writeData = mem_wdata_q;
    assign bus.mem_memWrite  = mem_write_q;
    assign bus.mem_memRead   = mem_read_q;

    // Second tag stage is the response cycle: pulses are decoded straight from registers.
    assign bus.p0_rvalid = tag2_q.valid && !tag2_q.port && !tag2_q.we;
    assign bus.p1_rvalid = tag2_q.valid &&  tag2_q.port && !tag2_q.we;
    assign bus.p0_err    = tag2_q.valid && !tag2_q.port &&  tag2_q.err;
    assign bus.p1_err    = tag2_q.valid &&  tag2_q.port &&  tag2_q.err;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model with its own copy of the memory.
module tb_data_mem_arbiter;

    localparam int DEPTH        = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int NRAND        = 400;
    localparam int NSLOT        = NRAND + 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    logic        exp_rv0 [NSLOT];
    logic        exp_rv1 [NSLOT];
    logic        exp_er0 [NSLOT];
    logic        exp_er1 [NSLOT];
    logic [31:0] exp_dt0 [NSLOT];
    logic [31:0] exp_dt1 [NSLOT];
    logic        exp_mw  [NSLOT];
    logic        exp_mr  [NSLOT];
    logic [31:0] exp_ma  [NSLOT];
    logic [31:0] exp_md  [NSLOT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: writes land before reads within each falling edge.
    always @(negedge clk) begin
        if (bus.mem_memWrite && bus.mem_address < DEPTH) begin
            ram[bus.mem_address[4:0]] = bus.mem_writeData;
        end
        if (bus.mem_memRead && bus.mem_address < DEPTH) begin
            bus.mem_readData = ram[bus.mem_address[4:0]];
        end
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive0(1'b1, 1'b0, 32'd5, 32'h0);
        drive1(1'b1, 1'b1, 32'd6, 32'hFFFF_FFFF);
        #3;
        n_checks++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b%b expected 00", bus.p0_gnt, bus.p1_gnt); end
        cyc(); cyc(); #2;
        n_checks++; if (bus.mem_memRead !== 1'b0 || bus.mem_memWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobes: got r=%b w=%b expected 0 0", bus.mem_memRead, bus.mem_memWrite); end
        n_checks++; if (bus.mem_address !== 32'h0 || bus.mem_writeData !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_bus: got %h %h expected 0 0", bus.mem_address, bus.mem_writeData); end
        n_checks++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || bus.p0_err !== 1'b0 || bus.p1_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: got %b%b%b%b expected 0000", bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err); end
        n_checks++; if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h %h expected 0 0", bus.p0_rdata, bus.p1_rdata); end
        cyc();
        reset = 1'b1;
        idle();
        drive0(1'b1, 1'b0, 32'd0, 32'h0);
        #2;
        n_checks++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL first_grant: got %b expected 1", bus.p0_gnt); end
        cyc(); idle(); #2;
        n_checks++; if (bus.mem_memRead !== 1'b1 || bus.mem_address !== 32'd0) begin n_fail++; $display("[TB] FAIL first_read_bus: got r=%b a=%h expected 1 0", bus.mem_memRead, bus.mem_address); end
        cyc(); #2;
        n_checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== init_word(0)) begin n_fail++; $display("[TB] FAIL first_read_data: got v=%b d=%h expected 1 %h", bus.p0_rvalid, bus.p0_rdata, init_word(0)); end
        cyc();
    endtask

    task automatic test_single_read();
        cyc(); drive0(1'b1, 1'b0, 32'd5, 32'h0); #2;
        n_checks++; if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0 || bus.p0_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL read_gnt: got g0=%b g1=%b st=%b expected 1 0 0", bus.p0_gnt, bus.p1_gnt, bus.p0_stall); end
        cyc(); idle(); #2;
        n_checks++; if (bus.mem_memRead !== 1'b1 || bus.mem_memWrite !== 1'b0 || bus.mem_address !== 32'd5) begin n_fail++; $display("[TB] FAIL read_mem_bus: got r=%b w=%b a=%h expected 1 0 5", bus.mem_memRead, bus.mem_memWrite, bus.mem_address); end
        n_checks++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL read_early_valid: got %b expected 0", bus.p0_rvalid); end
        cyc(); #2;
        n_checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hCAFE_F00D || bus.p0_err !== 1'b0) begin n_fail++; $display("[TB] FAIL read_resp: got v=%b d=%h e=%b expected 1 cafef00d 0", bus.p0_rvalid, bus.p0_rdata, bus.p0_err); end
        n_checks++; if (bus.mem_memRead !== 1'b0 || bus.p1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL read_idle_after: got r=%b v1=%b expected 0 0", bus.mem_memRead, bus.p1_rvalid); end
        cyc(); #2;
        n_checks++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("[TB] FAIL read_hold: got v=%b d=%h expected 0 cafef00d", bus.p0_rvalid, bus.p0_rdata); end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 7; i++) begin
            cyc();
            drive0(1'b1, 1'b0, 32'd1, 32'h0);
            drive1(1'b1, 1'b0, 32'd2, 32'h0);
            #2;
            n_checks++; if (bus.p0_gnt !== (i != 4) || bus.p1_gnt !== (i == 4) || bus.p0_stall !== (i == 4)) begin n_fail++; $display("[TB] FAIL starve_cycle%0d: got g0=%b g1=%b st=%b expected %b %b %b", i, bus.p0_gnt, bus.p1_gnt, bus.p0_stall, i != 4, i == 4, i == 4); end
        end
        cyc(); idle(); cyc(); cyc();
    endtask

    task automatic test_raw();
        cyc(); drive1(1'b1, 1'b1, 32'd7, 32'h1234_5678); #2;
        n_checks++; if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_wgnt: got g1=%b g0=%b expected 1 0", bus.p1_gnt, bus.p0_gnt); end
        cyc(); idle(); drive0(1'b1, 1'b0, 32'd7, 32'h0); #2;
        n_checks++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_rgnt: got %b expected 1", bus.p0_gnt); end
        n_checks++; if (bus.mem_memWrite !== 1'b1 || bus.mem_address !== 32'd7 || bus.mem_writeData !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL raw_write_bus: got w=%b a=%h d=%h expected 1 7 12345678", bus.mem_memWrite, bus.mem_address, bus.mem_writeData); end
        cyc(); idle(); #2;
        n_checks++; if (bus.mem_memRead !== 1'b1 || bus.mem_memWrite !== 1'b0 || bus.p1_rvalid !== 1'b0 || bus.p0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_cycle2: got r=%b w=%b v1=%b v0=%b expected 1 0 0 0", bus.mem_memRead, bus.mem_memWrite, bus.p1_rvalid, bus.p0_rvalid); end
        cyc(); #2;
        n_checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h1234_5678 || bus.p1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_resp: got v0=%b d=%h v1=%b expected 1 12345678 0", bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid); end
        cyc();
    endtask

    task automatic test_out_of_range();
        cyc(); drive1(1'b1, 1'b0, 32'd40, 32'h0); #2;
        n_checks++; if (bus.p1_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_gnt: got %b expected 1", bus.p1_gnt); end
        cyc(); idle(); drive0(1'b1, 1'b1, 32'd100, 32'hDEAD_BEEF); #2;
        n_checks++; if (bus.mem_memRead !== 1'b0 || bus.mem_memWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_rd_strobes: got r=%b w=%b expected 0 0", bus.mem_memRead, bus.mem_memWrite); end
        cyc(); idle(); #2;
        n_checks++; if (bus.p1_err !== 1'b1 || bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL oor_rd_resp: got e=%b v=%b d=%h expected 1 1 0", bus.p1_err, bus.p1_rvalid, bus.p1_rdata); end
        n_checks++; if (bus.mem_memWrite !== 1'b0 || bus.p0_err !== 1'b0 || bus.p0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_wr_bus: got w=%b e0=%b v0=%b expected 0 0 0", bus.mem_memWrite, bus.p0_err, bus.p0_rvalid); end
        cyc(); #2;
        n_checks++; if (bus.p0_err !== 1'b1 || bus.p0_rvalid !== 1'b0 || bus.p1_err !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_wr_resp: got e0=%b v0=%b e1=%b expected 1 0 0", bus.p0_err, bus.p0_rvalid, bus.p1_err); end
        cyc();
    endtask

    task automatic test_interleaved();
        cyc(); drive0(1'b1, 1'b0, 32'd2, 32'h0); #2;
        n_checks++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL inter_gnt0: got %b expected 1", bus.p0_gnt); end
        cyc(); idle(); drive1(1'b1, 1'b0, 32'd3, 32'h0); #2;
        n_checks++; if (bus.p1_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL inter_gnt1: got %b expected 1", bus.p1_gnt); end
        cyc(); idle(); drive0(1'b1, 1'b0, 32'd4, 32'h0); #2;
        n_checks++; if (bus.p0_gnt !== 1'b1 || bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== init_word(2)) begin n_fail++; $display("[TB] FAIL inter_resp_a: got g=%b v=%b d=%h expected 1 1 %h", bus.p0_gnt, bus.p0_rvalid, bus.p0_rdata, init_word(2)); end
        cyc(); idle(); #2;
        n_checks++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== init_word(3) || bus.p0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL inter_resp_b: got v1=%b d=%h v0=%b expected 1 %h 0", bus.p1_rvalid, bus.p1_rdata, bus.p0_rvalid, init_word(3)); end
        cyc(); #2;
        n_checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== init_word(4) || bus.p1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL inter_resp_c: got v0=%b d=%h v1=%b expected 1 %h 0", bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid, init_word(4)); end
        cyc();
    endtask

    task automatic test_reset_mid();
        cyc(); drive0(1'b1, 1'b0, 32'd5, 32'h0); #2;
        n_checks++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_gnt: got %b expected 1", bus.p0_gnt); end
        cyc(); idle(); reset = 1'b0; #1;
        n_checks++; if (bus.mem_memRead !== 1'b0 || bus.mem_address !== 32'h0 || bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rmid_clear: got r=%b a=%h d0=%h d1=%h expected 0 0 0 0", bus.mem_memRead, bus.mem_address, bus.p0_rdata, bus.p1_rdata); end
        cyc(); reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_checks++; if (bus.p0_rvalid !== 1'b0 || bus.p0_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_no_resp%0d: got v=%b e=%b expected 0 0", i, bus.p0_rvalid, bus.p0_err); end
            cyc();
        end
    endtask

    task automatic test_random();
        logic        pend [2];
        logic        we   [2];
        logic [31:0] addr [2];
        logic [31:0] wdat [2];
        logic [31:0] last0;
        logic [31:0] last1;
        int          lost;
        int          win;
        logic        oor;
        logic [31:0] rd;

        for (int i = 0; i < NSLOT; i++) begin
            exp_rv0[i] = 0; exp_rv1[i] = 0; exp_er0[i] = 0; exp_er1[i] = 0;
            exp_dt0[i] = 0; exp_dt1[i] = 0; exp_mw[i] = 0; exp_mr[i] = 0;
            exp_ma[i] = 0; exp_md[i] = 0;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];
        for (int p = 0; p < 2; p++) begin pend[p] = 0; we[p] = 0; addr[p] = 0; wdat[p] = 0; end
        last0 = 0; last1 = 0; lost = 0;

        cyc(); idle(); reset = 1'b0; #3; reset = 1'b1;

        for (int c = 0; c < NRAND + 3; c++) begin
            cyc();
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && c < NRAND && $urandom_range(0, 99) < 60) begin
                    pend[p] = 1;
                    we[p]   = 1'($urandom_range(0, 1));
                    addr[p] = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 200)) : 32'($urandom_range(0, 7));
                    wdat[p] = $urandom;
                end
            end
            drive0(pend[0], we[0], addr[0], wdat[0]);
            drive1(pend[1], we[1], addr[1], wdat[1]);

            win = -1;
            if (pend[1] && lost == STARVE_LIMIT) win = 1;
            else if (pend[0])                    win = 0;
            else if (pend[1])                    win = 1;
            if (pend[1] && win != 1) lost = (lost < STARVE_LIMIT) ? lost + 1 : lost;
            else                     lost = 0;

            if (win >= 0) begin
                oor = addr[win] >= 32'(DEPTH);
                rd  = 32'h0;
                if (!oor && we[win])  ref_mem[addr[win][4:0]] = wdat[win];
                if (!oor && !we[win]) rd = ref_mem[addr[win][4:0]];
                exp_mw[c+1] = we[win] && !oor;
                exp_mr[c+1] = !we[win] && !oor;
                exp_ma[c+1] = addr[win];
                exp_md[c+1] = wdat[win];
                if (win == 0) begin exp_rv0[c+2] = !we[win]; exp_er0[c+2] = oor; exp_dt0[c+2] = rd; end
                else          begin exp_rv1[c+2] = !we[win]; exp_er1[c+2] = oor; exp_dt1[c+2] = rd; end
            end

            #2;
            n_checks++; if (bus.p0_gnt !== (win == 0) || bus.p1_gnt !== (win == 1)) begin n_fail++; $display("[TB] FAIL rand_gnt c%0d: got %b%b expected %b%b", c, bus.p0_gnt, bus.p1_gnt, win == 0, win == 1); end
            n_checks++; if (bus.p0_stall !== (pend[0] && win != 0)) begin n_fail++; $display("[TB] FAIL rand_stall c%0d: got %b expected %b", c, bus.p0_stall, pend[0] && win != 0); end
            n_checks++; if (bus.mem_memWrite !== exp_mw[c] || bus.mem_memRead !== exp_mr[c]) begin n_fail++; $display("[TB] FAIL rand_strobes c%0d: got w=%b r=%b expected %b %b", c, bus.mem_memWrite, bus.mem_memRead, exp_mw[c], exp_mr[c]); end
            if (exp_mw[c] || exp_mr[c]) begin
                n_checks++; if (bus.mem_address !== exp_ma[c]) begin n_fail++; $display("[TB] FAIL rand_addr c%0d: got %h expected %h", c, bus.mem_address, exp_ma[c]); end
            end
            if (exp_mw[c]) begin
                n_checks++; if (bus.mem_writeData !== exp_md[c]) begin n_fail++; $display("[TB] FAIL rand_wdata c%0d: got %h expected %h", c, bus.mem_writeData, exp_md[c]); end
            end
            if (exp_rv0[c]) last0 = exp_dt0[c];
            if (exp_rv1[c]) last1 = exp_dt1[c];
            n_checks++; if (bus.p0_rvalid !== exp_rv0[c] || bus.p0_err !== exp_er0[c] || bus.p0_rdata !== last0) begin n_fail++; $display("[TB] FAIL rand_p0_resp c%0d: got v=%b e=%b d=%h expected %b %b %h", c, bus.p0_rvalid, bus.p0_err, bus.p0_rdata, exp_rv0[c], exp_er0[c], last0); end
            n_checks++; if (bus.p1_rvalid !== exp_rv1[c] || bus.p1_err !== exp_er1[c] || bus.p1_rdata !== last1) begin n_fail++; $display("[TB] FAIL rand_p1_resp c%0d: got v=%b e=%b d=%h expected %b %b %h", c, bus.p1_rvalid, bus.p1_err, bus.p1_rdata, exp_rv1[c], exp_er1[c], last1); end

            if (win >= 0) pend[win] = 0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.mem_readData = 32'h0;
        for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
        ram[5] = 32'hCAFE_F00D;
        idle();

        $display("[TB] starting data_mem_arbiter bench");
        test_reset();
        test_single_read();
        test_starvation();
        test_raw();
        test_out_of_range();
        test_interleaved();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
